// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle between the IF/MEM requesters and the arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req and operands until grant; memory stalls via port_ready.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wdata;
    logic              port_ready;
    logic [ADDR_W-1:0] port_rdata;
    logic              port_valid;
    logic              port_sel;
    logic [ADDR_W-1:0] port_addr;
    logic [ADDR_W-1:0] port_wdata;
    logic              port_we;
    logic              if_grant;
    logic              mem_grant;
    logic              if_done;
    logic              mem_done;
    logic [ADDR_W-1:0] rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, mem_req, mem_addr, mem_we, mem_wdata,
        input  port_ready, port_rdata,
        output port_valid, port_sel, port_addr, port_wdata, port_we,
        output if_grant, mem_grant, if_done, mem_done, rdata
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, mem_req, mem_addr, mem_we, mem_wdata,
        output port_ready, port_rdata,
        input  port_valid, port_sel, port_addr, port_wdata, port_we,
        input  if_grant, mem_grant, if_done, mem_done, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and data (MEM).
// Latency: grant one cycle after request sample, done one cycle after port_ready.
// Backpressure: access held with stable port_* until port_ready; losers keep requesting.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY_IF  = 2'd1;
    localparam logic [1:0] S_BUSY_MEM = 2'd2;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [1:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic              r_port_sel;
    logic [ADDR_W-1:0] r_port_addr;
    logic [ADDR_W-1:0] r_port_wdata;
    logic              r_port_we;
    logic              r_if_grant;
    logic              r_mem_grant;
    logic              r_if_done;
    logic              r_mem_done;
    logic [ADDR_W-1:0] r_rdata;

    logic              w_any_req;
    logic              w_if_wins;
    logic [3:0]        w_wait_after_mem;

    // Winner selection: MEM has priority unless IF has been starved MAX_WAIT times
    always_comb begin
        w_any_req        = bus.if_req | bus.mem_req;
        w_if_wins        = bus.if_req & (~bus.mem_req | (r_wait_cnt == WAIT_LIMIT));
        w_wait_after_mem = r_wait_cnt;
        if (bus.if_req && (r_wait_cnt < WAIT_LIMIT)) begin
            w_wait_after_mem = r_wait_cnt + 4'd1;
        end
    end

    // State machine, operand latching, grant/done pulses and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_port_sel   <= 1'b0;
            r_port_addr  <= '0;
            r_port_wdata <= '0;
            r_port_we    <= 1'b0;
            r_if_grant   <= 1'b0;
            r_mem_grant  <= 1'b0;
            r_if_done    <= 1'b0;
            r_mem_done   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_if_grant  <= 1'b0;
            r_mem_grant <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // port_ready is deliberately ignored here; port_sel keeps its last value
                    if (w_any_req) begin
                        if (w_if_wins) begin
                            r_state      <= S_BUSY_IF;
                            r_port_sel   <= 1'b0;
                            r_port_addr  <= bus.if_addr;
                            // IF never writes, so its write data is forced to zero
                            r_port_wdata <= '0;
                            r_port_we    <= 1'b0;
                            r_if_grant   <= 1'b1;
                            r_wait_cnt   <= 4'd0;
                        end else begin
                            r_state      <= S_BUSY_MEM;
                            r_port_sel   <= 1'b1;
                            r_port_addr  <= bus.mem_addr;
                            r_port_wdata <= bus.mem_wdata;
                            r_port_we    <= bus.mem_we;
                            r_mem_grant  <= 1'b1;
                            r_wait_cnt   <= w_wait_after_mem;
                        end
                    end
                end
                S_BUSY_IF, S_BUSY_MEM: begin
                    if (bus.port_ready) begin
                        r_rdata    <= bus.port_rdata;
                        r_if_done  <= (r_state == S_BUSY_IF);
                        r_mem_done <= (r_state == S_BUSY_MEM);
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.port_valid = (r_state != S_IDLE);
    assign bus.port_sel   = r_port_sel;
    assign bus.port_addr  = r_port_addr;
    assign bus.port_wdata = r_port_wdata;
    assign bus.port_we    = r_port_we;
    assign bus.if_grant   = r_if_grant;
    assign bus.mem_grant  = r_mem_grant;
    assign bus.if_done    = r_if_done;
    assign bus.mem_done   = r_mem_done;
    assign bus.rdata      = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 3;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port (0 none, 1 IF, 2 MEM) and what it expects to see
    int          m_owner;
    int          m_starved;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we, m_sel;
    logic        m_gi, m_gm, m_di, m_dm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_starved = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0;
        m_we = 0; m_sel = 0;
        m_gi = 0; m_gm = 0; m_di = 0; m_dm = 0;
    endtask

    // One clock edge of the access protocol, using the inputs present at that edge
    task automatic model_edge();
        bit take_if;
        m_gi = 0; m_gm = 0; m_di = 0; m_dm = 0;
        if (m_owner == 0) begin
            if (bus.if_req || bus.mem_req) begin
                take_if = bus.if_req && (!bus.mem_req || m_starved == MAX_WAIT);
                if (take_if) begin
                    m_owner = 1; m_sel = 0; m_gi = 1;
                    m_addr = bus.if_addr; m_wdata = 0; m_we = 0;
                    m_starved = 0;
                end else begin
                    m_owner = 2; m_sel = 1; m_gm = 1;
                    m_addr = bus.mem_addr; m_wdata = bus.mem_wdata; m_we = bus.mem_we;
                    if (bus.if_req) m_starved = (m_starved + 1 > MAX_WAIT) ? MAX_WAIT : m_starved + 1;
                end
            end
        end else if (bus.port_ready) begin
            m_rdata = bus.port_rdata;
            if (m_owner == 1) m_di = 1; else m_dm = 1;
            m_owner = 0;
        end
    endtask

    task automatic check_all();
        check("port_valid", 32'(bus.port_valid), 32'(m_owner != 0));
        check("port_sel",   32'(bus.port_sel),   32'(m_sel));
        check("port_addr",  bus.port_addr,       m_addr);
        check("port_wdata", bus.port_wdata,      m_wdata);
        check("port_we",    32'(bus.port_we),    32'(m_we));
        check("if_grant",   32'(bus.if_grant),   32'(m_gi));
        check("mem_grant",  32'(bus.mem_grant),  32'(m_gm));
        check("if_done",    32'(bus.if_done),    32'(m_di));
        check("mem_done",   32'(bus.mem_done),   32'(m_dm));
        check("rdata",      bus.rdata,           m_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Safety net so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.mem_req = 0; bus.mem_addr = 0; bus.mem_we = 0; bus.mem_wdata = 0;
        bus.port_ready = 0; bus.port_rdata = 0;
        model_reset();

        // Reset state
        rst_n = 0;
        #1;
        check_all();
        bus.if_req = 1; bus.if_addr = 32'h100;
        @(negedge clk);
        rst_n = 1;

        // IF-only access; first arbitration right after reset release
        tick();
        check("if_only_grant", 32'(bus.if_grant), 32'd1);
        check("if_only_addr", bus.port_addr, 32'h100);
        bus.if_req = 0; bus.port_ready = 1; bus.port_rdata = 32'hDEADBEEF;
        tick();
        check("if_only_done", 32'(bus.if_done), 32'd1);
        check("if_only_rdata", bus.rdata, 32'hDEADBEEF);

        // Spurious port_ready in IDLE
        bus.port_rdata = 32'h12345678;
        tick();
        check("idle_ready_rdata", bus.rdata, 32'hDEADBEEF);
        bus.port_ready = 0;

        // Simultaneous requests: MEM first, IF after mem_done
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h2000; bus.mem_wdata = 32'h55;
        tick();
        check("both_mem_grant", 32'(bus.mem_grant), 32'd1);
        check("both_port_we", 32'(bus.port_we), 32'd1);
        bus.mem_req = 0; bus.port_ready = 1; bus.port_rdata = 32'hA5A5;
        tick();
        bus.port_ready = 0;
        tick();
        check("both_if_after", 32'(bus.if_grant), 32'd1);
        bus.if_req = 0; bus.port_ready = 1;
        tick();
        bus.port_ready = 0;

        // Starvation: three MEM grants, forced IF, then MEM again (counter cleared)
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h3000;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("starve_mem", 32'(bus.mem_grant), 32'(k != 3));
            check("starve_if",  32'(bus.if_grant),  32'(k == 3));
            bus.port_ready = 1; bus.port_rdata = $urandom;
            tick();
            bus.port_ready = 0;
        end
        bus.if_req = 0; bus.mem_req = 0;
        tick();

        // Stretched access with IF address churning; also a MEM request dropped before grant
        bus.if_req = 1; bus.if_addr = 32'h300;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.if_addr = $urandom;
            bus.mem_req = (k == 2); bus.mem_addr = 32'h4000;
            tick();
            check("stretch_addr", bus.port_addr, 32'h300);
            check("stretch_nodone", 32'(bus.if_done), 32'd0);
        end
        bus.if_req = 0; bus.mem_req = 0; bus.port_ready = 1; bus.port_rdata = 32'h77;
        tick();
        check("stretch_done", 32'(bus.if_done), 32'd1);
        bus.port_ready = 0;
        tick();
        check("drop_no_grant", 32'(bus.mem_grant), 32'd0);

        // Reset during BUSY_MEM
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h5000; bus.mem_wdata = 32'h99;
        tick();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        bus.mem_req = 0; bus.port_ready = 1;
        rst_n = 1;
        tick();
        check("rst_no_done", 32'(bus.mem_done), 32'd0);
        tick();
        bus.port_ready = 0;

        // Randomized traffic obeying hold-until-grant
        for (int n = 0; n < 400; n++) begin
            if (m_gi) begin
                bus.if_req = 1'($urandom_range(0, 1)); bus.if_addr = $urandom;
            end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1; bus.if_addr = $urandom;
            end
            if (m_gm) begin
                bus.mem_req = 1'($urandom_range(0, 1));
                bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.mem_we = 1'($urandom_range(0, 1));
            end else if (!bus.mem_req && $urandom_range(0, 2) == 0) begin
                bus.mem_req = 1;
                bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.mem_we = 1'($urandom_range(0, 1));
            end
            bus.port_ready = ($urandom_range(0, 2) != 0);
            bus.port_rdata = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of address and data buses.
REQ-002 Parameter MAX_WAIT, default 3, number of consecutive IF losses tolerated before IF is forced to win (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch access request.
REQ-006 if_addr  input  ADDR_W  instruction-fetch address.
REQ-007 mem_req  input  1  data access request.
REQ-008 mem_addr  input  ADDR_W  data address.
REQ-009 mem_we  input  1  data write enable.
REQ-010 mem_wdata  input  ADDR_W  data write value.
REQ-011 port_ready  input  1  memory has completed the current access.
REQ-012 port_rdata  input  ADDR_W  memory read data, valid when port_ready=1.
REQ-013 port_valid  output  1  access in progress on shared port.
REQ-014 port_sel  output  1  drives the shared 2:1 address mux select; 0=IF, 1=MEM.
REQ-015 port_addr, port_wdata  output  ADDR_W each  latched address and write data of the granted requester.
REQ-016 port_we  output  1  latched write enable; always 0 for IF accesses.
REQ-017 if_grant, mem_grant  output  1 each  one-cycle grant pulses.
REQ-018 if_done, mem_done  output  1 each  one-cycle completion pulses.
REQ-019 rdata  output  ADDR_W  registered read data, valid in the done cycle.

Function
REQ-020 The arbiter SHALL implement three states: IDLE, BUSY_IF, BUSY_MEM.
REQ-021 In IDLE with no request, the state SHALL remain IDLE and port_valid SHALL be 0.
REQ-022 In IDLE at a clock edge with a request, the arbiter SHALL select a winner, latch its addr/we/wdata into port_* and enter BUSY_IF or BUSY_MEM.
REQ-023 Priority: MEM SHALL win when both request, unless wait_cnt == MAX_WAIT, in which case IF SHALL win.
REQ-024 wait_cnt (4 bits) SHALL increment, saturating at MAX_WAIT, each time MEM is granted while if_req=1; it SHALL clear when IF is granted.
REQ-025 The grant pulse of the winner SHALL be high exactly in the first BUSY cycle; requesters hold req and inputs until grant.
REQ-026 In BUSY_x, port_valid=1, port_sel fixed (0 for IF, 1 for MEM), port_* SHALL stay stable regardless of input changes.
REQ-027 In BUSY_x with port_ready=1 at an edge, rdata SHALL capture port_rdata, the matching done SHALL pulse for the next cycle, and the state SHALL return to IDLE.
REQ-028 port_ready while IDLE SHALL be ignored (no done, no rdata update).
REQ-029 Minimum access latency: request sampled at edge N, grant in cycle N+1, port_ready at edge N+1 yields done in cycle N+2; next arbitration at edge N+2.
REQ-030 A request deasserted before being granted SHALL be dropped with no grant.
REQ-031 Exactly one of if_grant/mem_grant and one of if_done/mem_done SHALL be high in any cycle, at most.
REQ-032 port_sel SHALL hold its last value in IDLE.

Reset
REQ-033 On rst_n=0, asynchronously: state IDLE, wait_cnt 0, port_valid 0, port_sel 0, port_addr/port_wdata/rdata 0, port_we 0, all grant/done 0.
REQ-034 Reset asserted mid-access SHALL abort it; no done SHALL be issued for the aborted access.
REQ-035 After rst_n rises, the first arbitration SHALL occur at the first following rising edge.

Verification
REQ-036 IF only: if_req=1, if_addr=0x100, port_ready one cycle later with rdata 0xDEADBEEF -> if_grant pulse, port_sel=0, port_addr=0x100, if_done with rdata=0xDEADBEEF.
REQ-037 Simultaneous: if_req=mem_req=1, mem_we=1, mem_addr=0x2000, mem_wdata=0x55 -> MEM granted first, port_sel=1, port_we=1; IF granted after mem_done.
REQ-038 Starvation, MAX_WAIT=3: if_req held, mem_req re-asserted every access -> three MEM grants, then IF grant, wait_cnt returns to 0.
REQ-039 Stretched access: port_ready held 0 for 5 BUSY cycles while if_addr changes -> port_addr stable, done only after port_ready=1.
REQ-040 Reset mid-access: rst_n=0 during BUSY_MEM -> all outputs 0 immediately, no mem_done after release.
REQ-041 Spurious port_ready=1 in IDLE -> no done pulse, rdata unchanged.
